// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven ROM fetch with a tagged instruction FIFO toward decode
module instr_fetch #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [W-1:0]               pc,
  input  logic                       flush,
  output logic                       rom_en,
  output logic [W-1:0]               rom_addr,
  input  logic [W-1:0]               rom_data,
  output logic [W-1:0]               instr,
  output logic [W-1:0]               instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic                       fetch_stall,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_i [DEPTH];
  logic [W-1:0] mem_p [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic req_valid;
  logic [W-1:0] req_pc;
  logic push, pop;
  assign fetch_stall = (count + CW'(req_valid)) >= CW'(DEPTH);
  assign rom_en = !reset && !flush && !fetch_stall;
  assign rom_addr = pc;
  assign instr_valid = (count != '0) && !flush;
  assign instr = mem_i[rd_ptr];
  assign instr_pc = mem_p[rd_ptr];
  assign push = req_valid && !flush;
  assign pop = instr_valid && instr_ready;
  // request tracking, FIFO writes and occupancy; flush drops everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      req_valid <= 1'b0;
      req_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_i[i] <= '0;
        mem_p[i] <= '0;
      end
    end else if (flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      req_valid <= 1'b0;
    end else begin
      req_valid <= rom_en;
      req_pc <= pc;
      if (push) begin
        mem_i[wr_ptr] <= rom_data;
        mem_p[wr_ptr] <= req_pc;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random and directed fetch traffic checked against a queue model
module tb_instr_fetch;
  logic clk = 0;
  logic reset, flush, instr_ready;
  logic [15:0] pc, rom_data, rom_addr, instr, instr_pc;
  logic rom_en, instr_valid, fetch_stall;
  logic [2:0] count;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic mreq_v = 0;
  logic [15:0] mreq_pc = 0, pcreg = 5;
  logic last_en;
  always #5 clk = ~clk;
  instr_fetch #(.DEPTH(4), .W(16)) dut (
    .clk(clk), .reset(reset), .pc(pc), .flush(flush), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_stall(fetch_stall),
    .count(count)
  );
  initial rom_data = 0;
  always @(posedge clk) if (rom_en) rom_data <= rom_addr + 16'h100;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic f, input logic rdy, input logic [15:0] tgt);
    logic st, en, vld;
    @(negedge clk);
    reset = r; flush = f; instr_ready = rdy; pc = pcreg;
    #1;
    st = (q.size() + int'(mreq_v)) >= 4;
    en = !r && !f && !st;
    vld = q.size() != 0 && !f;
    chk("fetch_stall", fetch_stall, st);
    chk("rom_en", rom_en, en);
    chk("rom_addr", rom_addr, pc);
    chk("instr_valid", instr_valid, vld);
    chk("count", count, q.size());
    chk("no_overflow", count <= 4, 1);
    if (vld) begin
      chk("instr", instr, q[0][31:16]);
      chk("instr_pc", instr_pc, q[0][15:0]);
    end
    last_en = en;
    if (r || f) begin
      q.delete();
      mreq_v = 0;
      pcreg = tgt;
    end else begin
      if (vld && rdy) void'(q.pop_front());
      if (mreq_v) q.push_back({mreq_pc + 16'h100, mreq_pc});
      mreq_v = en;
      mreq_pc = pc;
      if (en) pcreg = pcreg + 1;
    end
  endtask
  initial begin
    int n;
    reset = 1; flush = 0; instr_ready = 0; pc = 5;
    @(posedge clk);
    repeat (2) cyc(1, 0, 0, 5);
    repeat (12) cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, i % 2 == 0, 0);
    cyc(1, 0, 0, 0);
    n = 0;
    while (!(q.size() == 3 && mreq_v) && n < 20) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("reach_count3_inflight", n < 20, 1);
    cyc(0, 1, 0, 16'h40);
    repeat (8) cyc(0, 0, 1, 0);
    n = 0;
    while (q.size() != 2 && n < 20) begin
      cyc(0, 0, n % 2 == 1, 0);
      n++;
    end
    chk("reach_count2", n < 20, 1);
    cyc(1, 0, 0, 16'h77);
    @(negedge clk);
    #1;
    chk("post_reset_count", count, 0);
    chk("post_reset_valid", instr_valid, 0);
    chk("post_reset_instr", instr, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 127) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0 || i < 500 && i % 2 == 0, 16'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
